m68k_latch_bridge: RTL and testbench
====================================

M68K_LATCH_BRIDGE -- requirements
Module: m68k_latch_bridge

Interface
REQ-001 Parameter DTACK_WAIT, default 1, clk cycles from access accept to DTACK assertion; legal values 0-7.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m68kp_as_n, m68kp_rw  input  1 each  main CPU address strobe and read/write (1 = read).
REQ-005 m68kp_latch0_cs, m68kp_latch1_cs  input  1 each  main CPU decoded selects: latch0 = write to sound, latch1 = read from sound.
REQ-006 m68kp_din  input  16  main CPU write data; m68kp_dout  output  16  main CPU read data.
REQ-007 m68kp_dtack_n  output  1  main CPU data acknowledge, active-low.
REQ-008 m68ks_as_n, m68ks_rw, m68ks_latch0_cs, m68ks_latch1_cs  input  1 each  sound CPU equivalents: latch0 = read from main, latch1 = write to main.
REQ-009 m68ks_din  input  16; m68ks_dout  output  16; m68ks_dtack_n  output  1  sound CPU data, read data and acknowledge.
REQ-010 m68ks_irq_n  output  1  sound CPU interrupt request, active-low.
REQ-011 latch0_full, latch1_full  output  1 each  mailbox occupancy flags.

Function
REQ-012 Each CPU port SHALL run an independent FSM with states IDLE, WAIT, ACK.
REQ-013 IDLE->WAIT on the first cycle with (latch0_cs | latch1_cs) & !as_n; this cycle is the accept cycle; cs, rw and din are sampled here only.
REQ-014 WAIT SHALL count DTACK_WAIT cycles, then go to ACK; with DTACK_WAIT = 0, accept goes directly to ACK.
REQ-015 In ACK dtack_n SHALL be 0; ACK->IDLE on the cycle as_n is sampled 1; dtack_n returns to 1 on that same edge.
REQ-016 If as_n rises while in WAIT, the FSM SHALL return to IDLE without asserting dtack_n; the sampled data effect still applies.
REQ-017 Main write to latch0 at accept: latch0 <= m68kp_din, latch0_full <= 1.
REQ-018 Sound read of latch0 at accept: m68ks_dout <= latch0, latch0_full <= 0.
REQ-019 Sound write to latch1 at accept: latch1 <= m68ks_din, latch1_full <= 1.
REQ-020 Main read of latch1 at accept: m68kp_dout <= latch1, latch1_full <= 0.
REQ-021 Writes to a full latch SHALL overwrite; reads of an empty latch SHALL return the last stored value; both are acknowledged normally.
REQ-022 Same-cycle write and read of one latch: the reader gets the old value; the new value is stored; full ends at 1 (write wins).
REQ-023 A write to a read-direction select (e.g. main rw=0 with latch1_cs) SHALL be acknowledged and otherwise ignored; the same applies to a read of a write-direction select.
REQ-024 dout registers SHALL hold their value until the next read accept on that port.
REQ-025 An accept with both selects active SHALL be treated as a latch0 access.

Reset
REQ-026 On reset_n = 0, asynchronously: both FSMs to IDLE; dtack_n = 1; irq_n = 1; latches = 16'h0000; dout = 16'h0000; full flags = 0.
REQ-027 A reset during WAIT or ACK SHALL abort the access with no latch update after reset is released; the FSM resumes with a fresh accept only.

Configuration
REQ-028 With macro LATCH_IRQ_EN defined: m68ks_irq_n is registered !latch0_full, so it asserts the cycle after a main latch0 write and deasserts the cycle after a sound latch0 read.
REQ-029 Without LATCH_IRQ_EN: m68ks_irq_n SHALL be constant 1; all other behaviour is unchanged.

Verification
REQ-030 Main writes 16'h00A5 to latch0 (DTACK_WAIT = 1) -> m68kp_dtack_n = 0 two cycles after accept; latch0_full = 1; with LATCH_IRQ_EN, m68ks_irq_n = 0.
REQ-031 Sound then reads latch0 -> m68ks_dout = 16'h00A5; latch0_full = 0; m68ks_irq_n returns to 1 one cycle later.
REQ-032 Sound writes 16'h1234 to latch1 and main writes 16'h5678 to latch0 in the same cycle -> both latches updated, both full flags = 1, both DTACKs assert independently.
REQ-033 Same-cycle main write 16'hBEEF to latch0 and sound read of latch0 holding 16'h0001 -> m68ks_dout = 16'h0001; latch0 = 16'hBEEF; latch0_full = 1.
REQ-034 as_n held low for 10 cycles -> dtack_n stays 0 until as_n rises; a single accept only, no second update.
REQ-035 reset_n pulsed low during WAIT -> dtack_n = 1 and all flags and latches = 0 immediately; no DTACK after release until a new as_n falling access.

Source files
------------

// File: rtl/m68k_latch_bridge.sv
// Two-CPU mailbox bridge: main (p) and sound (s) 68k ports share two 16-bit latches with DTACK timing.
// Optional macro LATCH_IRQ_EN drives m68ks_irq_n from the latch0 occupancy flag.
module m68k_latch_bridge #(
   parameter int unsigned DTACK_WAIT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m68kp_as_n,
   input  logic        m68kp_rw,
   input  logic        m68kp_latch0_cs,
   input  logic        m68kp_latch1_cs,
   input  logic [15:0] m68kp_din,
   output logic [15:0] m68kp_dout,
   output logic        m68kp_dtack_n,
   input  logic        m68ks_as_n,
   input  logic        m68ks_rw,
   input  logic        m68ks_latch0_cs,
   input  logic        m68ks_latch1_cs,
   input  logic [15:0] m68ks_din,
   output logic [15:0] m68ks_dout,
   output logic        m68ks_dtack_n,
   output logic        m68ks_irq_n,
   output logic        latch0_full,
   output logic        latch1_full
);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   localparam logic [2:0] WaitLoad = (DTACK_WAIT == 0) ? 3'd0 : 3'(DTACK_WAIT - 1);

   // Index 0 is the main CPU port, index 1 the sound CPU port.
   state_e     state_q [2];
   state_e     state_d [2];
   logic [2:0] cnt_q   [2];
   logic [2:0] cnt_d   [2];
   logic [1:0] armed_q, armed_d;
   logic [1:0] as_n, sel, accept;

   logic [15:0] latch0_q, latch1_q;
   logic        p_wr0, p_rd1, s_rd0, s_wr1;

   assign as_n = {m68ks_as_n, m68kp_as_n};
   assign sel  = {m68ks_latch0_cs | m68ks_latch1_cs, m68kp_latch0_cs | m68kp_latch1_cs};

   // A port only accepts after as_n has been seen high since reset, so an
   // access cut short by reset cannot re-trigger on a still-low strobe.
   assign armed_d = armed_q | as_n;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         accept[i]  = 1'b0;
         case (state_q[i])
            StIdle: begin
               if (sel[i] && !as_n[i] && armed_q[i]) begin
                  accept[i]  = 1'b1;
                  cnt_d[i]   = WaitLoad;
                  state_d[i] = (DTACK_WAIT == 0) ? StAck : StWait;
               end
            end
            StWait: begin
               if (as_n[i]) begin
                  state_d[i] = StIdle;
               end else if (cnt_q[i] == 3'd0) begin
                  state_d[i] = StAck;
               end else begin
                  cnt_d[i] = cnt_q[i] - 3'd1;
               end
            end
            StAck: begin
               if (as_n[i]) begin
                  state_d[i] = StIdle;
               end
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= 3'd0;
         end
         armed_q <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         armed_q <= armed_d;
      end
   end

   // Both selects active decode as latch0; wrong-direction accesses fall through.
   assign p_wr0 = accept[0] & ~m68kp_rw & m68kp_latch0_cs;
   assign p_rd1 = accept[0] & m68kp_rw & ~m68kp_latch0_cs & m68kp_latch1_cs;
   assign s_rd0 = accept[1] & m68ks_rw & m68ks_latch0_cs;
   assign s_wr1 = accept[1] & ~m68ks_rw & ~m68ks_latch0_cs & m68ks_latch1_cs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         latch0_q    <= 16'h0000;
         latch1_q    <= 16'h0000;
         latch0_full <= 1'b0;
         latch1_full <= 1'b0;
         m68kp_dout  <= 16'h0000;
         m68ks_dout  <= 16'h0000;
      end else begin
         if (p_wr0) begin
            latch0_q    <= m68kp_din;
            latch0_full <= 1'b1;
         end else if (s_rd0) begin
            latch0_full <= 1'b0;
         end
         if (s_wr1) begin
            latch1_q    <= m68ks_din;
            latch1_full <= 1'b1;
         end else if (p_rd1) begin
            latch1_full <= 1'b0;
         end
         // Readers sample the pre-edge latch value, so a same-cycle write is not seen.
         if (s_rd0) m68ks_dout <= latch0_q;
         if (p_rd1) m68kp_dout <= latch1_q;
      end
   end

   assign m68kp_dtack_n = (state_q[0] != StAck);
   assign m68ks_dtack_n = (state_q[1] != StAck);

`ifdef LATCH_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_q <= 1'b1;
      else          irq_q <= ~latch0_full;
   end
   assign m68ks_irq_n = irq_q;
`else
   assign m68ks_irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_latch_bridge.sv
// Directed self-checking bench for m68k_latch_bridge (DTACK_WAIT = 1).
module tb_m68k_latch_bridge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        p_as_n, p_rw, p_cs0, p_cs1;
   logic [15:0] p_din, p_dout;
   logic        p_dtack_n;
   logic        s_as_n, s_rw, s_cs0, s_cs1;
   logic [15:0] s_din, s_dout;
   logic        s_dtack_n, s_irq_n, full0, full1;

   int errors = 0;
   int checks = 0;

`ifdef LATCH_IRQ_EN
   localparam logic IrqOn = 1'b0;
`else
   localparam logic IrqOn = 1'b1;
`endif

   always #5 clk = ~clk;

   m68k_latch_bridge #(.DTACK_WAIT(1)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .m68kp_as_n      (p_as_n),
      .m68kp_rw        (p_rw),
      .m68kp_latch0_cs (p_cs0),
      .m68kp_latch1_cs (p_cs1),
      .m68kp_din       (p_din),
      .m68kp_dout      (p_dout),
      .m68kp_dtack_n   (p_dtack_n),
      .m68ks_as_n      (s_as_n),
      .m68ks_rw        (s_rw),
      .m68ks_latch0_cs (s_cs0),
      .m68ks_latch1_cs (s_cs1),
      .m68ks_din       (s_din),
      .m68ks_dout      (s_dout),
      .m68ks_dtack_n   (s_dtack_n),
      .m68ks_irq_n     (s_irq_n),
      .latch0_full     (full0),
      .latch1_full     (full1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic p_idle();
      p_as_n = 1'b1; p_rw = 1'b1; p_cs0 = 1'b0; p_cs1 = 1'b0;
   endtask

   task automatic s_idle();
      s_as_n = 1'b1; s_rw = 1'b1; s_cs0 = 1'b0; s_cs1 = 1'b0;
   endtask

   task automatic p_go(input logic rw, input logic cs0, input logic cs1, input logic [15:0] d);
      p_as_n = 1'b0; p_rw = rw; p_cs0 = cs0; p_cs1 = cs1; p_din = d;
   endtask

   task automatic s_go(input logic rw, input logic cs0, input logic cs1, input logic [15:0] d);
      s_as_n = 1'b0; s_rw = rw; s_cs0 = cs0; s_cs1 = cs1; s_din = d;
   endtask

   initial begin
      p_din = 16'h0; s_din = 16'h0;
      p_idle(); s_idle();
      reset_n = 1'b0;
      #12;
      chk("rst_p_dtack", {15'd0, p_dtack_n}, 16'd1);
      chk("rst_s_dtack", {15'd0, s_dtack_n}, 16'd1);
      chk("rst_irq", {15'd0, s_irq_n}, 16'd1);
      chk("rst_full", {14'd0, full1, full0}, 16'd0);
      chk("rst_p_dout", p_dout, 16'h0000);
      chk("rst_s_dout", s_dout, 16'h0000);
      reset_n = 1'b1;
      tick(2);

      // Main writes 00A5 to latch0
      p_go(1'b0, 1'b1, 1'b0, 16'h00A5);
      tick();
      chk("wr_a5_full", {15'd0, full0}, 16'd1);
      chk("wr_a5_dtack_wait", {15'd0, p_dtack_n}, 16'd1);
      tick();
      chk("wr_a5_dtack", {15'd0, p_dtack_n}, 16'd0);
      chk("wr_a5_irq", {15'd0, s_irq_n}, {15'd0, IrqOn});
      p_idle();
      tick();
      chk("wr_a5_release", {15'd0, p_dtack_n}, 16'd1);

      // Sound reads latch0
      s_go(1'b1, 1'b1, 1'b0, 16'h0);
      tick();
      chk("rd_a5_dout", s_dout, 16'h00A5);
      chk("rd_a5_full", {15'd0, full0}, 16'd0);
      tick();
      chk("rd_a5_dtack", {15'd0, s_dtack_n}, 16'd0);
      chk("rd_a5_irq_clr", {15'd0, s_irq_n}, 16'd1);
      s_idle();
      tick();

      // Simultaneous sound write latch1 / main write latch0
      s_go(1'b0, 1'b0, 1'b1, 16'h1234);
      p_go(1'b0, 1'b1, 1'b0, 16'h5678);
      tick();
      chk("dual_full", {14'd0, full1, full0}, 16'd3);
      tick();
      chk("dual_dtack", {14'd0, s_dtack_n, p_dtack_n}, 16'd0);
      p_idle(); s_idle();
      tick();
      p_go(1'b1, 1'b0, 1'b1, 16'h0);
      s_go(1'b1, 1'b1, 1'b0, 16'h0);
      tick();
      chk("dual_p_dout", p_dout, 16'h1234);
      chk("dual_s_dout", s_dout, 16'h5678);
      chk("dual_full_clr", {14'd0, full1, full0}, 16'd0);
      tick();
      p_idle(); s_idle();
      tick();

      // Same-cycle write/read of latch0
      p_go(1'b0, 1'b1, 1'b0, 16'h0001);
      tick(2);
      p_idle();
      tick();
      p_go(1'b0, 1'b1, 1'b0, 16'hBEEF);
      s_go(1'b1, 1'b1, 1'b0, 16'h0);
      tick();
      chk("race_s_dout", s_dout, 16'h0001);
      chk("race_full", {15'd0, full0}, 16'd1);
      tick();
      p_idle(); s_idle();
      tick();
      s_go(1'b1, 1'b1, 1'b0, 16'h0);
      tick();
      chk("race_latch", s_dout, 16'hBEEF);
      tick();
      s_idle();
      tick();

      // Wrong-direction write: main write with latch1 select
      p_go(1'b0, 1'b0, 1'b1, 16'hDEAD);
      tick(2);
      chk("wrongdir_dtack", {15'd0, p_dtack_n}, 16'd0);
      chk("wrongdir_full1", {15'd0, full1}, 16'd0);
      p_idle();
      tick();
      p_go(1'b1, 1'b0, 1'b1, 16'h0);
      tick();
      chk("wrongdir_p_dout", p_dout, 16'h1234);
      tick();
      p_idle();
      tick();

      // as_n held low for 10 cycles: single accept only
      p_go(1'b0, 1'b1, 1'b0, 16'h0C0C);
      tick(2);
      chk("hold_dtack_start", {15'd0, p_dtack_n}, 16'd0);
      p_din = 16'hFFFF;
      s_go(1'b1, 1'b1, 1'b0, 16'h0);
      tick();
      chk("hold_s_dout", s_dout, 16'h0C0C);
      chk("hold_full_clr", {15'd0, full0}, 16'd0);
      s_idle();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("hold_dtack", {15'd0, p_dtack_n}, 16'd0);
         chk("hold_no_reaccept", {15'd0, full0}, 16'd0);
      end
      p_idle();
      tick();
      chk("hold_release", {15'd0, p_dtack_n}, 16'd1);

      // as_n rises during WAIT: abort without DTACK, data effect kept
      p_go(1'b0, 1'b1, 1'b0, 16'h7777);
      tick();
      p_idle();
      tick();
      chk("abort_dtack", {15'd0, p_dtack_n}, 16'd1);
      chk("abort_full", {15'd0, full0}, 16'd1);
      tick();

      // Reset pulsed during WAIT
      p_go(1'b0, 1'b1, 1'b0, 16'h4242);
      s_go(1'b0, 1'b0, 1'b1, 16'h2424);
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("rstwait_dtack", {14'd0, s_dtack_n, p_dtack_n}, 16'd3);
      chk("rstwait_full", {14'd0, full1, full0}, 16'd0);
      chk("rstwait_p_dout", p_dout, 16'h0000);
      chk("rstwait_s_dout", s_dout, 16'h0000);
      chk("rstwait_irq", {15'd0, s_irq_n}, 16'd1);
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rstwait_no_dtack", {14'd0, s_dtack_n, p_dtack_n}, 16'd3);
         chk("rstwait_no_update", {14'd0, full1, full0}, 16'd0);
      end
      p_idle(); s_idle();
      tick();
      p_go(1'b1, 1'b0, 1'b1, 16'h0);
      tick(2);
      chk("rstwait_new_dtack", {15'd0, p_dtack_n}, 16'd0);
      chk("rstwait_latch1_clr", p_dout, 16'h0000);
      p_idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
